// File: rtl/shift_sequencer_if.sv
// Job-request and result handshakes for the shift sequencer.
// slave is the sequencer side and master is the requester/consumer side.
interface shift_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] operand;
    logic [AMT_W-1:0]  amount;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport slave (
        input  in_valid, op, operand, amount, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, op, operand, amount, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Full-amount SLL/SRL/SRA/ROR built from chunks of up to STEP_MAX bits. SHIFT_SATURATE_EN shortcuts amounts >= 8.
// Latency: 1 cycle when nothing is left to shift, otherwise ceil(rem/STEP_MAX)+1 cycles.
// Backpressure: RESULT is held in DONE until out_ready. A new job is accepted only in IDLE.
module shift_sequencer #(
    parameter int DATA_W   = 8,
    parameter int AMT_W    = 8,
    parameter int STEP_MAX = 7
) (
    input logic                clk,
    input logic                reset_n,
    shift_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;
    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic [1:0]          op_q, op_d;
    logic [2:0]          step;
    logic [DATA_W-1:0]   shifted;
    logic [2*DATA_W-1:0] rot;
    logic [AMT_W-1:0]    rem_next;
    logic [AMT_W-1:0]    acc_rem;
    logic                in_ready_c, out_valid_c, busy_c;

    always_comb begin
        step     = (rem_q < STEP_LIM) ? rem_q[2:0] : STEP_LIM[2:0];
        rem_next = rem_q - AMT_W'(step);
        rot      = {data_q, data_q} >> step;
        case (op_q)
            OP_SLL:  shifted = data_q << step;
            OP_SRL:  shifted = data_q >> step;
            OP_SRA:  shifted = $signed(data_q) >>> step;
            default: shifted = rot[DATA_W-1:0];
        endcase
    end

    // A rotate by a multiple of the width is the identity, so only the low bits matter.
    assign acc_rem = (bus.op == OP_ROR) ? {{(AMT_W-3){1'b0}}, bus.amount[2:0]} : bus.amount;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        op_d        = op_q;
        result_d    = result_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    op_d   = bus.op;
                    data_d = bus.operand;
                    rem_d  = acc_rem;
                    if (acc_rem == '0) begin
                        state_d  = DONE;
                        result_d = bus.operand;
                    end else begin
                        state_d = RUN;
                    end
`ifdef SHIFT_SATURATE_EN
                    if (bus.op != OP_ROR && bus.amount >= AMT_W'(8)) begin
                        state_d  = DONE;
                        rem_d    = '0;
                        result_d = (bus.op == OP_SRA) ? {DATA_W{bus.operand[DATA_W-1]}} : '0;
                    end
`endif
                end
            end
            RUN: begin
                busy_c = 1'b1;
                data_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    result_d = shifted;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed jobs with hand-computed results; a monitor pops expected result and DONE cycle on each out_valid rise.
module tb_shift_sequencer;
    localparam logic [1:0] SLL = 2'd0, SRL = 2'd1, SRA = 2'd2, ROR = 2'd3;
`ifdef SHIFT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    exp_t sb[$];
    logic ov_prev = 1'b0;

    shift_sequencer_if #(.DATA_W(8), .AMT_W(8)) bus ();
    shift_sequencer #(.DATA_W(8), .AMT_W(8), .STEP_MAX(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each new result is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_output: result=%0h with empty scoreboard", bus.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(bus.result), 32'(e.res));
                    check("done_cycle", cyc, e.cyc);
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic job(input logic [1:0] op, input logic [7:0] opnd, input logic [7:0] amt,
                       input logic [7:0] exp_res, input int lat, input int hold);
        int n;
        exp_t e;
        if (SAT && op != ROR && amt >= 8'd8) lat = 1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_job", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.operand = opnd;
        bus.amount = amt;
        @(posedge clk); #1;
        e.res = exp_res;
        e.cyc = cyc + lat - 1;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.operand = 8'($urandom);
        bus.amount = 8'($urandom);
        if (lat > 1) check("busy_in_run", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i == 2);
            bus.operand = 8'hA5;
            bus.amount = 8'd1;
            @(posedge clk); #1;
            check("hold_result", 32'(bus.result), 32'(exp_res));
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("ready_after_handoff", 32'(bus.in_ready), 32'd1);
        check("valid_after_handoff", 32'(bus.out_valid), 32'd0);
        check("result_held_idle", 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        exp_t e;
        bus.in_valid = 1'b0;
        bus.op = 2'd0;
        bus.operand = 8'd0;
        bus.amount = 8'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", 32'(bus.result), 32'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        job(SLL, 8'h01, 8'd7,   8'h80, 2,  0);
        job(SRA, 8'h80, 8'd20,  8'hFF, 4,  0);
        job(ROR, 8'h81, 8'd9,   8'hC0, 2,  0);
        job(ROR, 8'h81, 8'd8,   8'h81, 1,  0);
        job(SRL, 8'hF0, 8'd200, 8'h00, 30, 5);
        job(SLL, 8'h3C, 8'd0,   8'h3C, 1,  0);
        job(SRA, 8'h40, 8'd10,  8'h00, 3,  0);
        job(SLL, 8'hFF, 8'd8,   8'h00, 3,  0);
        job(ROR, 8'h12, 8'd255, 8'h24, 2,  0);
        job(SRL, 8'hAA, 8'd3,   8'h15, 2,  0);
        job(SRA, 8'h90, 8'd3,   8'hF2, 2,  0);

        // Abandon a long SRL with an asynchronous reset partway through.
        bus.in_valid = 1'b1;
        bus.op = SRL;
        bus.operand = 8'hFF;
        bus.amount = 8'd50;
        @(posedge clk); #1;
        if (SAT) begin
            e.res = 8'h00;
            e.cyc = cyc;
            sb.push_back(e);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_result", 32'(bus.result), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        job(SLL, 8'h03, 8'd2, 8'h0C, 2, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
